// File: rtl/shift_nib_in_pstore.sv
// ---------------------------------------------------------------------------
// shift_nib_in_pstore
//   Receive side of the Pi nibble link. The Pi presents 4-bit nibbles
//   (most significant nibble first) on rising edges of sclk. When le is high
//   on an sclk rise, the assembled word is committed into a holding register.
//   The held word is offered to TI-side logic through a valid/ready handshake.
//   All Pi-side pins are asynchronous to clk and are synchronized here.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   sclk        Pi shift clock (async), rising edge is the event
//   select      Pi channel select (async), active high
//   le          latch enable (async), commit instead of shift on sclk rise
//   nin[3:0]    nibble data (async), most significant nibble first
//   dout[W-1:0] committed word, W = 4*NIBBLES
//   dout_valid  dout holds a word not yet consumed
//   dout_ready  consumer takes dout when dout_valid & dout_ready
//   frame_err   one-cycle pulse: commit with a nibble count other than NIBBLES
//   overrun     sticky: commit arrived while dout was still held; word dropped
//   err_clr     synchronous clear of overrun (a same-cycle new overrun wins)
// ---------------------------------------------------------------------------
module shift_nib_in_pstore #(
    parameter int SYNC_STAGES = 2,
    parameter int NIBBLES     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sclk,
    input  logic                   select,
    input  logic                   le,
    input  logic [3:0]             nin,
    output logic [4*NIBBLES-1:0]   dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   frame_err,
    output logic                   overrun,
    input  logic                   err_clr
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NIBBLES);

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] FILLING = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;
    localparam logic [1:0] OVER    = 2'd3;

    // Synchronizer: {sclk, select, le, nin} travel together so the data used
    // at an edge is the sample taken alongside the newer sclk sample.
    logic [6:0] sync_q [SYNC_STAGES];
    logic       sclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            sclk_prev <= 1'b0;
        end else begin
            sync_q[0] <= {sclk, select, le, nin};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sclk_prev <= sync_q[SYNC_STAGES-1][6];
        end
    end

    logic       sclk_s;
    logic       sel_s;
    logic       le_s;
    logic [3:0] nin_s;
    logic       sclk_rise;

    always_comb begin
        sclk_s    = sync_q[SYNC_STAGES-1][6];
        sel_s     = sync_q[SYNC_STAGES-1][5];
        le_s      = sync_q[SYNC_STAGES-1][4];
        nin_s     = sync_q[SYNC_STAGES-1][3:0];
        sclk_rise = sclk_s & ~sclk_prev;
    end

    // Assembly shift register and nibble-count FSM
    logic [1:0]    state;
    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;
    logic [W+3:0]  sr_cat;
    logic [W-1:0]  sr_shift;

    // Concatenate then truncate so NIBBLES=1 needs no empty slice
    always_comb begin
        sr_cat   = {sr, nin_s};
        sr_shift = sr_cat[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            sr    <= '0;
            cnt   <= '0;
        end else if (!sel_s) begin
            state <= EMPTY;
            sr    <= '0;
            cnt   <= '0;
        end else if (sclk_rise) begin
            if (le_s) begin
                state <= EMPTY;
                sr    <= '0;
                cnt   <= '0;
            end else begin
                sr <= sr_shift;
                case (state)
                    EMPTY: begin
                        cnt   <= CNT_ONE;
                        state <= (NIBBLES == 1) ? FULL : FILLING;
                    end
                    FILLING: begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt + CNT_ONE == CNT_FULL) begin
                            state <= FULL;
                        end
                    end
                    FULL:    state <= OVER;
                    OVER:    state <= OVER;
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    // Commit decode
    logic commit;
    logic load;
    logic drop;
    logic bad_frame;

    always_comb begin
        commit    = sclk_rise & sel_s & le_s;
        load      = commit & (state == FULL) & (~dout_valid | dout_ready);
        drop      = commit & (state == FULL) & dout_valid & ~dout_ready;
        bad_frame = commit & (state != FULL);
    end

    // Holding register and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= bad_frame;
            // A load in the same cycle as a consume keeps valid high
            if (load) begin
                dout       <= sr;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_nib_in_pstore.sv
// ---------------------------------------------------------------------------
// tb_shift_nib_in_pstore
//   Drives the Pi-side pins with directed and randomized nibble/commit
//   sequences and compares the TI-side outputs against a nibble-count model.
// ---------------------------------------------------------------------------
module tb_shift_nib_in_pstore;

    localparam int S  = 2;
    localparam int NB = 2;
    localparam int W  = 4 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sclk;
    logic         select;
    logic         le;
    logic [3:0]   nin;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         frame_err;
    logic         overrun;
    logic         err_clr;

    int errors = 0;
    int checks = 0;

    // Reference model: number of nibbles received and the last NB of them
    int           m_cnt;
    logic [W-1:0] m_sr;
    logic [W-1:0] m_dout;
    logic         m_valid;
    logic         m_ovr;

    shift_nib_in_pstore #(.SYNC_STAGES(S), .NIBBLES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .select     (select),
        .le         (le),
        .nin        (nin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_ferr);
        check_eq({tag, ".frame_err"}, 32'(frame_err), 32'(exp_ferr));
        check_eq({tag, ".dout"}, 32'(dout), 32'(m_dout));
        check_eq({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
        check_eq({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_sr    = '0;
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        logic [W+3:0] unused;
        unused = '0;
        @(negedge clk);
        rst_n = 1'b0;
        sclk  = 1'b0;
        #1;
        model_reset();
        check_all(tag, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (S + 2) @(negedge clk);
    endtask

    // One Pi transaction: set pins, raise sclk, check at the effect cycle and
    // the cycle after, then drop sclk. rp = ready outside the effect cycle,
    // re/ce = ready/err_clr during the effect cycle.
    task automatic pi_op(input string tag, input logic sel, input logic l, input logic [3:0] nib,
                         input logic rp, input logic re, input logic ce);
        logic         ferr;
        logic         ovr_set;
        logic         loaded;
        logic [W+3:0] cat;
        @(negedge clk);
        select     = sel;
        le         = l;
        nin        = nib;
        dout_ready = rp;
        if (rp && m_valid) m_valid = 1'b0;
        if (!sel) begin
            m_cnt = 0;
            m_sr  = '0;
        end
        repeat (S + 2) @(negedge clk);
        sclk = 1'b1;
        repeat (S) @(negedge clk);
        dout_ready = re;
        err_clr    = ce;
        ferr    = 1'b0;
        ovr_set = 1'b0;
        loaded  = 1'b0;
        if (sel) begin
            if (l) begin
                if (m_cnt == NB) begin
                    if (!m_valid || re) begin
                        m_dout  = m_sr;
                        m_valid = 1'b1;
                        loaded  = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end else begin
                    ferr = 1'b1;
                end
                m_cnt = 0;
                m_sr  = '0;
            end else begin
                if (m_cnt <= NB) m_cnt++;
                cat  = {m_sr, nib};
                m_sr = cat[W-1:0];
            end
        end
        if (!loaded && re && m_valid) m_valid = 1'b0;
        if (ovr_set) m_ovr = 1'b1;
        else if (ce) m_ovr = 1'b0;
        @(negedge clk);
        check_all({tag, "@edge"}, ferr);
        dout_ready = rp;
        err_clr    = 1'b0;
        if (rp && m_valid) m_valid = 1'b0;
        @(negedge clk);
        check_all({tag, "@after"}, 1'b0);
        sclk = 1'b0;
        repeat (S + 2) @(negedge clk);
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        m_valid    = 1'b0;
        check_all(tag, 1'b0);
    endtask

    task automatic clear_err(input string tag);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ovr   = 1'b0;
        check_all(tag, 1'b0);
    endtask

    task automatic send_word(input string tag, input logic [7:0] w, input logic re);
        pi_op({tag, ".n0"}, 1'b1, 1'b0, w[7:4], 1'b0, 1'b0, 1'b0);
        pi_op({tag, ".n1"}, 1'b1, 1'b0, w[3:0], 1'b0, 1'b0, 1'b0);
        pi_op({tag, ".le"}, 1'b1, 1'b1, 4'h0, 1'b0, re, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        sclk       = 1'b0;
        select     = 1'b0;
        le         = 1'b0;
        nin        = 4'h0;
        dout_ready = 1'b0;
        err_clr    = 1'b0;
        model_reset();

        // 1: reset state
        repeat (3) @(negedge clk);
        check_all("reset", 1'b0);
        rst_n = 1'b1;
        repeat (S + 4) @(negedge clk);
        check_all("reset_idle", 1'b0);

        // 2: basic word
        send_word("t2", 8'hAF, 1'b0);
        check_eq("t2.word", 32'(dout), 32'h000000AF);
        accept("t2.accept");

        // 3: short frame, then over-long frame
        pi_op("t3.n0", 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
        pi_op("t3.le", 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        pi_op("t3.o1", 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
        pi_op("t3.o2", 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        pi_op("t3.o3", 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
        pi_op("t3.ole", 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);

        // 4: overrun, clear, same-cycle ready + commit
        send_word("t4.w12", 8'h12, 1'b0);
        send_word("t4.w34", 8'h34, 1'b0);
        check_eq("t4.ovr", 32'(overrun), 32'd1);
        check_eq("t4.kept", 32'(dout), 32'h00000012);
        clear_err("t4.clr");
        send_word("t4.w56", 8'h56, 1'b1);
        check_eq("t4.w56val", 32'(dout_valid), 32'd1);
        check_eq("t4.w56dat", 32'(dout), 32'h00000056);
        // overrun set while err_clr is high in the same cycle: set wins
        pi_op("t4.s0", 1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
        pi_op("t4.s1", 1'b1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0);
        pi_op("t4.sle", 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
        clear_err("t4.clr2");
        accept("t4.accept");

        // 5: deselect aborts a partial word
        pi_op("t5.n0", 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
        pi_op("t5.d0", 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0);
        pi_op("t5.d1", 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        send_word("t5", 8'h5C, 1'b0);
        check_eq("t5.word", 32'(dout), 32'h0000005C);

        // 6: reset mid-word with a word held
        pi_op("t6.n0", 1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0);
        do_reset("t6.rst");
        send_word("t6", 8'hAF, 1'b0);
        check_eq("t6.word", 32'(dout), 32'h000000AF);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset("rnd.rst");
            end else begin
                pi_op("rnd",
                      1'($urandom_range(0, 7) != 0),
                      1'($urandom_range(0, 3) == 0),
                      4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 3) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
